// File: rtl/shift_issue.sv
// Decode-and-issue stage for MIPS R-type shift instructions: decodes funct into
// shifter controls and buffers operand sets in a two-entry skid buffer.
module shift_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt_imm,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [4:0]  dest,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sh_op1,
    output logic [5:0]  sh_shamt,
    output logic [1:0]  sh_operation,
    output logic [4:0]  out_dest,
    output logic        out_illegal
);

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10
    } shift_op_e;

    typedef struct packed {
        logic [31:0] op1;
        logic [5:0]  shamt;
        shift_op_e   operation;
        logic [4:0]  dest;
        logic        illegal;
    } entry_t;

    entry_t main_q, skid_q, dec;
    logic   main_valid, skid_valid;
    logic   accept, xfer;

    // Only the low five bits of rs form a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_val[31:5];

    always_comb begin
        dec.op1       = rt_val;
        dec.shamt     = 6'd0;
        dec.operation = OP_SLL;
        dec.dest      = dest;
        dec.illegal   = 1'b0;
        case (funct)
            6'b000000: begin dec.operation = OP_SLL; dec.shamt = {1'b0, shamt_imm};   end
            6'b000010: begin dec.operation = OP_SRL; dec.shamt = {1'b0, shamt_imm};   end
            6'b000011: begin dec.operation = OP_SRA; dec.shamt = {1'b0, shamt_imm};   end
            6'b000100: begin dec.operation = OP_SLL; dec.shamt = {1'b0, rs_val[4:0]}; end
            6'b000110: begin dec.operation = OP_SRL; dec.shamt = {1'b0, rs_val[4:0]}; end
            6'b000111: begin dec.operation = OP_SRA; dec.shamt = {1'b0, rs_val[4:0]}; end
            default:   dec.illegal = 1'b1;
        endcase
    end

    // in_ready depends only on skid_valid, so no combinational path from out_ready.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign xfer     = main_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; data registers are reset too so outputs are never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (xfer || !main_valid) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid    = main_valid;
    assign sh_op1       = main_q.op1;
    assign sh_shamt     = main_q.shamt;
    assign sh_operation = main_q.operation;
    assign out_dest     = main_q.dest;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_shift_issue.sv
// Self-checking bench for shift_issue: decode vector table plus hand-written
// backpressure, flush and asynchronous-reset sequences.
module tb_shift_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [5:0]  funct;
    logic [4:0]  shamt_imm;
    logic [31:0] rs_val, rt_val;
    logic [4:0]  dest;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] sh_op1;
    logic [5:0]  sh_shamt;
    logic [1:0]  sh_operation;
    logic [4:0]  out_dest;
    logic        out_illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .shamt_imm(shamt_imm), .rs_val(rs_val), .rt_val(rt_val),
        .dest(dest), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .sh_op1(sh_op1), .sh_shamt(sh_shamt), .sh_operation(sh_operation),
        .out_dest(out_dest), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [5:0]  funct;
        logic [4:0]  shamt_imm;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  dest;
        logic [1:0]  exp_op;
        logic [5:0]  exp_shamt;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] si,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d);
        in_valid  = v;
        funct     = f;
        shamt_imm = si;
        rs_val    = rs;
        rt_val    = rt;
        dest      = d;
    endtask

    // Advance through one rising edge and stop on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " out_valid"},    32'(out_valid),    32'd0);
        check({tag, " in_ready"},     32'(in_ready),     32'd1);
        check({tag, " sh_op1"},       sh_op1,            32'd0);
        check({tag, " sh_shamt"},     32'(sh_shamt),     32'd0);
        check({tag, " sh_operation"}, 32'(sh_operation), 32'd0);
        check({tag, " out_dest"},     32'(out_dest),     32'd0);
        check({tag, " out_illegal"},  32'(out_illegal),  32'd0);
    endtask

    initial begin
        vecs[0] = '{6'b000000, 5'd4,  32'h0000_0000, 32'h0000_00F1, 5'd3,  2'b10, 6'd4,  1'b0};
        vecs[1] = '{6'b000010, 5'd31, 32'h0000_0000, 32'hDEAD_BEEF, 5'd7,  2'b00, 6'd31, 1'b0};
        vecs[2] = '{6'b000011, 5'd0,  32'h0000_001F, 32'h8000_0001, 5'd31, 2'b01, 6'd0,  1'b0};
        vecs[3] = '{6'b000100, 5'd9,  32'h1234_5678, 32'h0000_0001, 5'd1,  2'b10, 6'd24, 1'b0};
        vecs[4] = '{6'b000110, 5'd2,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 5'd10, 2'b00, 6'd31, 1'b0};
        vecs[5] = '{6'b000111, 5'd0,  32'hFFFF_FFE5, 32'h8000_0000, 5'd12, 2'b01, 6'd5,  1'b0};
        vecs[6] = '{6'b100000, 5'd7,  32'h0000_0003, 32'h0000_0055, 5'd4,  2'b10, 6'd0,  1'b1};
        vecs[7] = '{6'b000001, 5'd3,  32'h0000_0002, 32'hA5A5_A5A5, 5'd5,  2'b10, 6'd0,  1'b1};
        vecs[8] = '{6'b000101, 5'd1,  32'h0000_0011, 32'h0000_0000, 5'd6,  2'b10, 6'd0,  1'b1};

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Back-to-back decode vectors with out_ready held high.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].funct, vecs[i].shamt_imm, vecs[i].rs_val, vecs[i].rt_val, vecs[i].dest);
            step();
            check($sformatf("v%0d out_valid", i),    32'(out_valid),    32'd1);
            check($sformatf("v%0d in_ready", i),     32'(in_ready),     32'd1);
            check($sformatf("v%0d sh_op1", i),       sh_op1,            vecs[i].rt_val);
            check($sformatf("v%0d sh_shamt", i),     32'(sh_shamt),     32'(vecs[i].exp_shamt));
            check($sformatf("v%0d sh_operation", i), 32'(sh_operation), 32'(vecs[i].exp_op));
            check($sformatf("v%0d out_dest", i),     32'(out_dest),     32'(vecs[i].dest));
            check($sformatf("v%0d out_illegal", i),  32'(out_illegal),  32'(vecs[i].exp_ill));
        end
        drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
        step();
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure: A then B fill both entries; C must be refused.
        out_ready = 1'b0;
        drive(1'b1, 6'b000000, 5'd1, 32'd0, 32'h0000_00AA, 5'd1);
        step();
        check("bp A out_valid", 32'(out_valid), 32'd1);
        check("bp A in_ready",  32'(in_ready),  32'd1);
        check("bp A out_dest",  32'(out_dest),  32'd1);
        drive(1'b1, 6'b000010, 5'd2, 32'd0, 32'h0000_00BB, 5'd2);
        step();
        check("bp B in_ready",  32'(in_ready),  32'd0);
        check("bp B hold dest", 32'(out_dest),  32'd1);
        check("bp B hold op1",  sh_op1,         32'h0000_00AA);
        drive(1'b1, 6'b000011, 5'd3, 32'd0, 32'h0000_00CC, 5'd3);
        step();
        check("bp C in_ready",  32'(in_ready),  32'd0);
        check("bp C hold dest", 32'(out_dest),  32'd1);
        check("bp C hold shamt", 32'(sh_shamt), 32'd1);
        drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
        out_ready = 1'b1;
        step();
        check("bp xfer A out_valid", 32'(out_valid),    32'd1);
        check("bp xfer A dest B",    32'(out_dest),     32'd2);
        check("bp xfer A op1 B",     sh_op1,            32'h0000_00BB);
        check("bp xfer A op B",      32'(sh_operation), 32'd0);
        check("bp xfer A in_ready",  32'(in_ready),     32'd1);
        step();
        check("bp xfer B out_valid", 32'(out_valid), 32'd0);

        // Flush with both entries full and a simultaneous offer.
        out_ready = 1'b0;
        drive(1'b1, 6'b000000, 5'd1, 32'd0, 32'h1, 5'd8);
        step();
        drive(1'b1, 6'b000000, 5'd2, 32'd0, 32'h2, 5'd9);
        step();
        check("fl full in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 6'b000010, 5'd5, 32'd0, 32'h3, 5'd10);
        step();
        check("fl out_valid", 32'(out_valid), 32'd0);
        check("fl in_ready",  32'(in_ready),  32'd1);
        flush = 1'b0;
        drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
        step();
        check("fl not captured", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with both entries full.
        drive(1'b1, 6'b000111, 5'd0, 32'h0000_0007, 32'hCAFE_0001, 5'd11);
        step();
        drive(1'b1, 6'b100000, 5'd0, 32'd0, 32'hCAFE_0002, 5'd12);
        step();
        check("rs full in_ready", 32'(in_ready),  32'd0);
        check("rs full out_dest", 32'(out_dest),  32'd11);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async rst");
        rst = 1'b0;
        drive(1'b1, 6'b000110, 5'd0, 32'h0000_0003, 32'h0000_F00D, 5'd13);
        step();
        check("post rst out_valid", 32'(out_valid), 32'd1);
        check("post rst sh_op1",    sh_op1,         32'h0000_F00D);
        check("post rst sh_shamt",  32'(sh_shamt),  32'd3);
        check("post rst out_dest",  32'(out_dest),  32'd13);
        drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  the decode stage presents a shift instruction.
REQ-005 in_ready  output  1  the block can accept an instruction this cycle.
REQ-006 funct  input  6  MIPS R-type funct field.
REQ-007 shamt_imm  input  5  instruction shamt field.
REQ-008 rs_val  input  32  rs operand value; supplies the variable shift amount.
REQ-009 rt_val  input  32  rt operand value; the value to be shifted.
REQ-010 dest  input  5  destination register index.
REQ-011 flush  input  1  synchronous pipeline kill.
REQ-012 out_valid  output  1  a shifter operand set is presented.
REQ-013 out_ready  input  1  the consumer accepts the operand set this cycle.
REQ-014 sh_op1  output  32  drives the shifter op1 input.
REQ-015 sh_shamt  output  6  drives the shifter shamt input.
REQ-016 sh_operation  output  2  drives the shifter operation input: 00 SRL, 01 SRA, 10 SLL.
REQ-017 out_dest  output  5  destination index travelling with the operand set.
REQ-018 out_illegal  output  1  the presented entry carried an unsupported funct.

Function
REQ-019 Accept condition: in_valid && in_ready at a rising edge.
REQ-020 Transfer condition: out_valid && out_ready at a rising edge.
REQ-021 Decode table, all values zero-extended to 6 bits:

| funct | sh_operation | sh_shamt |
|---|---|---|
| 000000 | 10 | shamt_imm |
| 000010 | 00 | shamt_imm |
| 000011 | 01 | shamt_imm |
| 000100 | 10 | rs_val[4:0] |
| 000110 | 00 | rs_val[4:0] |
| 000111 | 01 | rs_val[4:0] |

REQ-022 Any other funct is still accepted, decoded as sh_operation=10 with sh_shamt=0, and flagged with out_illegal=1.
REQ-023 sh_op1 = rt_val unmodified for every funct; rs_val[31:5] is ignored.
REQ-024 sh_operation=11 is never driven.
REQ-025 Storage is a two-entry skid buffer: a main register (drives the outputs) and a skid register.
REQ-026 Each entry holds op1, shamt, operation, dest, illegal and a valid bit.
REQ-027 in_ready = !skid_valid and is a registered value only, with no combinational path from out_ready.
REQ-028 out_valid = main_valid; all data outputs come directly from main-register flops.
REQ-029 Latency is one cycle: data accepted at edge N is on the outputs after edge N, provided main was empty or was transferring at edge N.
REQ-030 Accept while main is empty or transferring: the decoded entry loads into main.
REQ-031 Accept while main is valid and not transferring: the entry loads into skid, so in_ready is 0 next cycle.
REQ-032 Transfer while skid is valid: skid moves to main, skid_valid clears and in_ready returns to 1; no accept is possible in that cycle because in_ready=0.
REQ-033 Transfer with skid empty and no accept: main_valid clears.
REQ-034 Main entry stability: while out_valid=1 and out_ready=0, all outputs hold stable.
REQ-035 Ordering: entries leave strictly in acceptance order; none is dropped or duplicated.
REQ-036 Sustained throughput is one entry per cycle when out_ready stays 1.
REQ-037 Flush at an edge clears main_valid and skid_valid and overrides any simultaneous accept or transfer; in_ready=1 the next cycle.
REQ-038 Data fields of invalid entries are don't-care but must not be X after reset.

Reset
REQ-039 rst asserted clears main_valid and skid_valid immediately, without waiting for clk.
REQ-040 rst asserted zeroes all data registers immediately, so out_valid=0, in_ready=1, sh_op1=0, sh_shamt=0, sh_operation=00, out_dest=0, out_illegal=0.
REQ-041 Reset mid-operation discards both entries.
REQ-042 The first accept is possible at the first rising edge after rst deasserts.

Verification
REQ-043 Reset, then SLL funct=000000, shamt_imm=4, rt_val=0x0000_00F1, dest=3, out_ready=1 -> next cycle out_valid=1, sh_op1=0xF1, sh_shamt=4, sh_operation=10, out_dest=3.
REQ-044 SRAV funct=000111, rs_val=0xFFFF_FFE5, rt_val=0x8000_0000 -> sh_shamt=5, sh_operation=01, sh_op1=0x8000_0000.
REQ-045 out_ready=0, two back-to-back accepts A then B -> in_ready=0 after B; then out_ready=1 -> A transfers, then B; no loss, order preserved.
REQ-046 funct=100000 (ADD) -> out_illegal=1, sh_operation=10, sh_shamt=0.
REQ-047 Both entries full, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, the new instruction is not captured.
REQ-048 rst pulsed between clock edges with both entries full -> out_valid=0 and in_ready=1 before the next edge.
